// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART state encoding and default frame parameters
package uart_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_tx_baud_counter.sv
// baud_counter: bit-period timer, pulses tick on the last cycle of each bit
module baud_counter import uart_tx_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt_q;
  assign tick = enable && cnt_q == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clock) begin
    if (reset || !enable || tick) cnt_q <= '0;
    else cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte in, 8N1-style asynchronous frame out on tx
module uart_tx import uart_tx_pkg::*; #(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx
);
  localparam int BW = $clog2(DATA_BITS + 1);
  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, ready_q, ready_d, busy_q, busy_d;
  logic tick;
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock (clock),
    .reset (reset),
    .enable(state_q != IDLE),
    .tick  (tick)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      // tx is registered, so it is loaded with the next bit on the boundary edge
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + BW'(1);
        state_d = bit_q == BW'(DATA_BITS - 1) ? STOP : DATA;
        tx_d    = bit_q == BW'(DATA_BITS - 1) ? 1'b1 : shift_q[1];
      end
      STOP: if (tick) begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end
  assign ready = ready_q;
  assign busy  = busy_q;
  assign tx    = tx_q;
endmodule
